// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver.
// Each raw line goes through a two-flop synchroniser and a run-length
// deglitch filter. Falling edges of the filtered clock then drive a
// start / 8 data (LSB first) / odd parity / stop deserialiser. Good bytes
// and frame errors are reported as one-cycle pulses.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  // The filter switches on the cycle that would complete FILTER_LEN mismatches.
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  // The timeout fires on the TIMEOUT_CYCLES-th edge after the last fall.
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [2:0] ERR_START   = 3'b001;
  localparam logic [2:0] ERR_PARITY  = 3'b010;
  localparam logic [2:0] ERR_STOP    = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT = 3'b100;

  // Odd parity: the eight data bits plus the parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Line index 0 is the PS/2 clock, index 1 is the PS/2 data.
  logic [1:0]     sync1_q, sync1_d;
  logic [1:0]     sync2_q, sync2_d;
  logic [1:0]     filt_q,  filt_d;
  logic [FCW-1:0] fcnt_q [2];
  logic [FCW-1:0] fcnt_d [2];
  logic           clk_dly_q, clk_dly_d;

  logic [1:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_ok_q, par_ok_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;

  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           rx_err_q, rx_err_d;
  logic [2:0]     err_code_q, err_code_d;
  logic           busy_q, busy_d;

  logic           fall_s;
  logic           bit_s;

  // Synchronise both lines, then require a stable run of FILTER_LEN samples before the filtered value follows.
  always_comb begin
    sync1_d   = {ps2_data, ps2_clk};
    sync2_d   = sync1_q;
    clk_dly_d = filt_q[0];
    filt_d    = filt_q;
    fcnt_d[0] = fcnt_q[0];
    fcnt_d[1] = fcnt_q[1];
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = {FCW{1'b0}};
        end else begin
          filt_d[i] = filt_q[i];
          fcnt_d[i] = fcnt_q[i] + FCW'(1);
        end
      end else begin
        filt_d[i] = filt_q[i];
        fcnt_d[i] = {FCW{1'b0}};
      end
    end
  end

  assign fall_s = clk_dly_q & ~filt_q[0];
  assign bit_s  = filt_q[1];

  // Frame FSM: shift in bits on each filtered clock fall, check framing, and watch for stalled frames.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    err_code_d = err_code_q;

    if (fall_s || (state_q == ST_IDLE)) begin
      to_cnt_d = {TCW{1'b0}};
    end else begin
      to_cnt_d = to_cnt_q + TCW'(1);
    end

    if (!rx_en) begin
      // Disabled: drop any partial frame silently.
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      to_cnt_d  = {TCW{1'b0}};
    end else if ((state_q != ST_IDLE) && !fall_s && (to_cnt_q == TO_LAST)) begin
      // Device stopped clocking mid-frame: discard the partial byte.
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      to_cnt_d   = {TCW{1'b0}};
      rx_err_d   = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_START;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_ok_d = odd_parity_ok(shift_q, bit_s);
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!bit_s) begin
            // A bad stop bit outranks a bad parity bit.
            rx_err_d   = 1'b1;
            err_code_d = ERR_STOP;
          end else if (!par_ok_q) begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_PARITY;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Register every stage; a synchronous reset returns lines to idle-high and clears all frame state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= {FCW{1'b0}};
      fcnt_q[1]  <= {FCW{1'b0}};
      clk_dly_q  <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_ok_q   <= 1'b0;
      to_cnt_q   <= {TCW{1'b0}};
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      err_code_q <= 3'b000;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      clk_dly_q  <= clk_dly_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      to_cnt_q   <= to_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign err_code = err_code_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Testbench for ps2_rx_frame: table of whole frames plus hand-written
// sequences for start error, timeout, glitch, reset and enable handling.
module tb_ps2_rx_frame;

  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int H  = 30;   // half PS/2 bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [2:0] err_code;
  logic       busy;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_en    (rx_en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int valid_cyc = 0;
  int err_cyc = 0;
  int last_fall_k = 0;
  int checks = 0;
  int errors = 0;

  // Edge counter: after edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (rx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       start_b;
    logic       par_b;
    logic       stop_b;
    int         exp_valid;
    int         exp_err;
    logic [2:0] exp_code;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send the first nbits bits (bit 0 first); data set while clk high, sampled on clk fall.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(H);
      ps2_clk = 1'b0;
      last_fall_k = cyc + 1;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(2 * H);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  int v0, e0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1, 0, 3'b000, 8'hA5};
    vecs[1] = '{8'hFA, 1'b0, 1'b1, 1'b1, 1, 0, 3'b000, 8'hFA};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1, 0, 3'b000, 8'h00};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1, 0, 3'b000, 8'hFF};
    vecs[4] = '{8'h12, 1'b0, 1'b0, 1'b1, 0, 1, 3'b010, 8'hFF};
    vecs[5] = '{8'h12, 1'b0, 1'b0, 1'b0, 0, 1, 3'b011, 8'hFF};

    rst = 1'b1; rx_en = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(3);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset rx_err", 32'(rx_err), 32'h0);
    check("reset err_code", 32'(err_code), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(5);

    // Table of complete frames.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      send_bits({vecs[i].stop_b, vecs[i].par_b, vecs[i].data, vecs[i].start_b}, 11);
      check($sformatf("vec%0d valid pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d err pulses", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d err_code", i), 32'(err_code), 32'(vecs[i].exp_code));
      if (vecs[i].exp_valid == 1) begin
        check($sformatf("vec%0d valid latency", i), 32'(valid_cyc - last_fall_k), 32'(FL + 2));
      end else begin
        check($sformatf("vec%0d err latency", i), 32'(err_cyc - last_fall_k), 32'(FL + 2));
      end
    end

    // Start bit sampled high.
    e0 = err_cnt;
    send_bits(11'h7FF, 1);
    check("start err pulses", 32'(err_cnt - e0), 32'd1);
    check("start err_code", 32'(err_code), 32'b001);
    check("start busy", 32'(busy), 32'h0);

    // Frame stalls after 5 data bits.
    e0 = err_cnt;
    send_bits(frame(8'h5A, 1'b1, 1'b1), 6);
    check("stall busy", 32'(busy), 32'h1);
    check("stall no err yet", 32'(err_cnt - e0), 32'd0);
    tick(TO + 100);
    check("timeout err pulses", 32'(err_cnt - e0), 32'd1);
    check("timeout err_code", 32'(err_code), 32'b100);
    check("timeout latency", 32'(err_cyc - last_fall_k), 32'(FL + 2 + TO));
    check("timeout busy", 32'(busy), 32'h0);
    check("timeout rx_data", 32'(rx_data), 32'hFF);

    // 3-cycle glitch on clk while idle.
    v0 = valid_cnt; e0 = err_cnt;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(40);
    check("glitch busy", 32'(busy), 32'h0);
    check("glitch err pulses", 32'(err_cnt - e0), 32'd0);
    check("glitch valid pulses", 32'(valid_cnt - v0), 32'd0);

    // Reset after 4 data bits.
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(frame(8'h3C, 1'b1, 1'b1), 5);
    check("pre-rst busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick(1);
    check("rst rx_data", 32'(rx_data), 32'h00);
    check("rst err_code", 32'(err_code), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst rx_valid", 32'(rx_valid), 32'h0);
    check("rst rx_err", 32'(rx_err), 32'h0);
    rst = 1'b0;
    tick(5);
    check("rst no err pulses", 32'(err_cnt - e0), 32'd0);
    check("rst no valid pulses", 32'(valid_cnt - v0), 32'd0);
    send_bits(frame(8'h3C, 1'b1, 1'b1), 11);
    check("post-rst valid pulses", 32'(valid_cnt - v0), 32'd1);
    check("post-rst rx_data", 32'(rx_data), 32'h3C);

    // Receiver disabled for a whole frame, then enabled.
    v0 = valid_cnt; e0 = err_cnt;
    rx_en = 1'b0;
    tick(2);
    send_bits(frame(8'h55, 1'b1, 1'b1), 11);
    check("disabled valid pulses", 32'(valid_cnt - v0), 32'd0);
    check("disabled err pulses", 32'(err_cnt - e0), 32'd0);
    check("disabled rx_data", 32'(rx_data), 32'h3C);
    check("disabled busy", 32'(busy), 32'h0);
    rx_en = 1'b1;
    tick(5);
    send_bits(frame(8'h55, 1'b1, 1'b1), 11);
    check("enabled valid pulses", 32'(valid_cnt - v0), 32'd1);
    check("enabled rx_data", 32'(rx_data), 32'h55);

    check("valid and err together", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
